// File: rtl/fast_square_capture_pkg.sv
// Shared definitions for the fast_square capture buffer: frame sync word,
// FSM state encodings and drain-phase encodings.
package fast_square_capture_pkg;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hFA57;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PH_HDR_SYNC = 2'd0,
        PH_HDR_CNT  = 2'd1,
        PH_SAMP_I   = 2'd2,
        PH_SAMP_Q   = 2'd3
    } phase_e;

    // A buffered pair keeps I in the upper half so drain order matches word order.
    function automatic logic [31:0] packPair(input logic [15:0] iVal, input logic [15:0] qVal);
        return {iVal, qVal};
    endfunction

endpackage

// File: rtl/fast_square_capture_ram.sv
// Simple dual-port sample buffer: synchronous write, registered one-cycle read.
// The read register holds its value while rd_en_i is low.
module fast_square_capture_ram #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fast_square_capture.sv
// Captures strobed I/Q pairs while record is high, then drains them as a
// framed 16-bit stream (sync, count, I0, Q0, ...) over a valid/ready handshake.
module fast_square_capture
    import fast_square_capture_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter logic [15:0] SYNC_WORD  = DEFAULT_SYNC_WORD
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                record,
    input  logic                data_in_strobe,
    input  logic [15:0]         i_in,
    input  logic [15:0]         q_in,
    input  logic [DEPTH_LOG2:0] capture_len,
    output logic [15:0]         rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                busy,
    output logic                overrun
);

    typedef logic [DEPTH_LOG2:0]   cnt_t;
    typedef logic [DEPTH_LOG2-1:0] addr_t;

    localparam cnt_t DEPTH = cnt_t'(1) << DEPTH_LOG2;

    state_e      state_q;
    phase_e      phase_q;
    addr_t       wr_ptr_q;
    cnt_t        rd_ptr_q;
    cnt_t        count_q;
    cnt_t        eff_len_q;
    logic [15:0] rd_data_q;
    logic        rd_valid_q;
    logic        busy_q;
    logic        overrun_q;

    cnt_t        eff_len_d;
    cnt_t        count_d;
    cnt_t        rd_ptr_d;
    logic        xfer;
    logic        wr_en;
    logic        ram_rd_en;
    addr_t       ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic [15:0] count_word;

    assign eff_len_d  = (capture_len == '0 || capture_len > DEPTH) ? DEPTH : capture_len;
    assign count_d    = count_q + cnt_t'(1);
    assign rd_ptr_d   = rd_ptr_q + cnt_t'(1);
    assign xfer       = rd_valid_q & rd_ready;
    assign wr_en      = (state_q == ST_CAPTURE) && record && data_in_strobe;
    assign count_word = 16'(count_q);

    // Pair 0 is fetched during the header words; each I transfer prefetches the
    // next pair so the RAM output already holds it when that pair's I is due.
    assign ram_rd_en   = (state_q == ST_DRAIN) &&
                         ((phase_q == PH_HDR_SYNC) || (phase_q == PH_HDR_CNT) ||
                          ((phase_q == PH_SAMP_I) && xfer));
    assign ram_rd_addr = (phase_q == PH_SAMP_I) ? rd_ptr_d[DEPTH_LOG2-1:0]
                                                : rd_ptr_q[DEPTH_LOG2-1:0];

    fast_square_capture_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (32)
    ) u_ram (
        .clock_i   (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (packPair(i_in, q_in)),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (ram_rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_HDR_SYNC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            eff_len_q  <= DEPTH;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if ((state_q == ST_DRAIN) && record && data_in_strobe) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (record) begin
                        state_q   <= ST_CAPTURE;
                        wr_ptr_q  <= '0;
                        count_q   <= '0;
                        eff_len_q <= eff_len_d;
                        busy_q    <= 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    if (!record) begin
                        if (count_q != '0) begin
                            state_q    <= ST_DRAIN;
                            phase_q    <= PH_HDR_SYNC;
                            rd_ptr_q   <= '0;
                            rd_data_q  <= SYNC_WORD;
                            rd_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (data_in_strobe) begin
                        wr_ptr_q <= wr_ptr_q + addr_t'(1);
                        count_q  <= count_d;
                        if (count_d == eff_len_q) begin
                            state_q    <= ST_DRAIN;
                            phase_q    <= PH_HDR_SYNC;
                            rd_ptr_q   <= '0;
                            rd_data_q  <= SYNC_WORD;
                            rd_valid_q <= 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (xfer) begin
                        case (phase_q)
                            PH_HDR_SYNC: begin
                                rd_data_q <= count_word;
                                phase_q   <= PH_HDR_CNT;
                            end
                            PH_HDR_CNT: begin
                                rd_data_q <= ram_rd_data[31:16];
                                phase_q   <= PH_SAMP_I;
                            end
                            PH_SAMP_I: begin
                                rd_data_q <= ram_rd_data[15:0];
                                rd_ptr_q  <= rd_ptr_d;
                                phase_q   <= PH_SAMP_Q;
                            end
                            PH_SAMP_Q: begin
                                // rd_ptr_q already counts the pair whose Q just left.
                                if (rd_ptr_q == count_q) begin
                                    rd_valid_q <= 1'b0;
                                    state_q    <= ST_IDLE;
                                    busy_q     <= 1'b0;
                                end else begin
                                    rd_data_q <= ram_rd_data[31:16];
                                    phase_q   <= PH_SAMP_I;
                                end
                            end
                            default: phase_q <= PH_HDR_SYNC;
                        endcase
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    rd_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule
